// File: rtl/svm_feed_pkg.sv
// svm_feed_pkg: shared types and lane helper for the SVM feature feeder
package svm_feed_pkg;
  typedef enum logic {MOD_VALENCE = 1'b0, MOD_AROUSAL = 1'b1} modality_e;
  typedef enum logic {W_VAL = 1'b0, W_ARO = 1'b1} wr_state_e;
  function automatic int lane_lo(input int j, input int nbits);
    return j * nbits;
  endfunction
endpackage

// File: rtl/svm_feature_frame_buf.sv
// svm_feature_frame_buf: one ping-pong vector buffer with full flag and modality tag
module svm_feature_frame_buf
  import svm_feed_pkg::*;
#(
  parameter int NBITS       = 16,
  parameter int F_WIDTH     = 10,
  parameter int LOG_F_WIDTH = $clog2(F_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [LOG_F_WIDTH-1:0]   wr_idx,
  input  logic [NBITS-1:0]         wr_data,
  input  logic                     set_full,
  input  modality_e                set_mod,
  input  logic                     clear_full,
  output logic [NBITS*F_WIDTH-1:0] data,
  output logic                     full,
  output modality_e                modality
);
  logic [NBITS*F_WIDTH-1:0] lanes_q, lanes_d;
  logic                     full_q, full_d;
  modality_e                mod_q, mod_d;
  always_comb begin
    lanes_d = lanes_q;
    if (wr_en) lanes_d[lane_lo(int'(wr_idx), NBITS) +: NBITS] = wr_data;
    full_d = set_full ? 1'b1 : clear_full ? 1'b0 : full_q;
    mod_d  = set_full ? set_mod : mod_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q <= '0;
      full_q  <= 1'b0;
      mod_q   <= MOD_VALENCE;
    end else begin
      lanes_q <= lanes_d;
      full_q  <= full_d;
      mod_q   <= mod_d;
    end
  end
  assign data     = lanes_q;
  assign full     = full_q;
  assign modality = mod_q;
endmodule

// File: rtl/svm_feature_feeder.sv
// svm_feature_feeder: packs serial features into ping-pong valence/arousal vectors for the SVM
module svm_feature_feeder
  import svm_feed_pkg::*;
#(
  parameter int NBITS       = 16,
  parameter int F_WIDTH     = 10,
  parameter int LOG_F_WIDTH = $clog2(F_WIDTH),
  parameter int CNT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBITS-1:0]         s_feature,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [NBITS*F_WIDTH-1:0] in_features,
  output logic                     fin_valid,
  input  logic                     fin_ready,
  output logic                     fout_modality,
  output logic [CNT_BITS-1:0]      entries_sent,
  output logic                     frame_err
);
  logic [NBITS*F_WIDTH-1:0] buf_data [2];
  logic [1:0]               buf_full;
  modality_e                buf_mod [2];
  logic                     wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [LOG_F_WIDTH-1:0]   idx_q, idx_d;
  wr_state_e                state_q, state_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     acc, last_lane, done, fire;
  assign s_ready       = !buf_full[wr_sel_q];
  assign fin_valid     = buf_full[rd_sel_q];
  assign in_features   = buf_data[rd_sel_q];
  assign fout_modality = buf_mod[rd_sel_q];
  assign entries_sent  = cnt_q;
  assign frame_err     = err_q;
  assign acc       = s_valid && s_ready;
  assign last_lane = idx_q == LOG_F_WIDTH'(F_WIDTH - 1);
  assign done      = acc && last_lane;
  assign fire      = fin_valid && fin_ready;
  for (genvar g = 0; g < 2; g++) begin : g_buf
    svm_feature_frame_buf #(.NBITS(NBITS), .F_WIDTH(F_WIDTH), .LOG_F_WIDTH(LOG_F_WIDTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (acc && wr_sel_q == 1'(g)),
      .wr_idx    (idx_q),
      .wr_data   (s_feature),
      .set_full  (done && wr_sel_q == 1'(g)),
      .set_mod   (state_q == W_ARO ? MOD_AROUSAL : MOD_VALENCE),
      .clear_full(fire && rd_sel_q == 1'(g)),
      .data      (buf_data[g]),
      .full      (buf_full[g]),
      .modality  (buf_mod[g])
    );
  end
  always_comb begin
    idx_d    = acc ? (last_lane ? '0 : idx_q + 1'b1) : idx_q;
    wr_sel_d = wr_sel_q ^ done;
    state_d  = done ? (state_q == W_VAL ? W_ARO : W_VAL) : state_q;
    rd_sel_d = rd_sel_q ^ fire;
    cnt_d    = cnt_q + ((fire && fout_modality) ? CNT_BITS'(1) : CNT_BITS'(0));
    err_d    = err_q | (acc && (s_last != (last_lane && state_q == W_ARO)));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      wr_sel_q <= 1'b0;
      state_q  <= W_VAL;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      wr_sel_q <= wr_sel_d;
      state_q  <= state_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_svm_feature_feeder.sv
// tb_svm_feature_feeder: directed stimulus with a queue-based reference model
module tb_svm_feature_feeder;
  localparam int NB = 16;
  localparam int FW = 10;
  localparam int W  = NB * FW;
  typedef struct packed {logic [W-1:0] d; logic m;} vec_t;
  logic          clk = 0;
  logic          rst;
  logic [NB-1:0] s_feature;
  logic          s_valid, s_last, s_ready;
  logic [W-1:0]  in_features;
  logic          fin_valid, fin_ready, fout_modality, frame_err;
  logic [15:0]   entries_sent;
  int            total = 0, bad = 0, stalls = 0;
  vec_t          pend[$], log_q[$];
  logic [NB-1:0] part[$];
  int            beat_i = 0, vec_n = 0;
  logic [15:0]   cnt_e = 0;
  logic          err_e = 0;
  svm_feature_feeder dut (
    .clk(clk), .rst(rst), .s_feature(s_feature), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .in_features(in_features), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .fout_modality(fout_modality), .entries_sent(entries_sent), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete(); part.delete(); log_q.delete();
      beat_i = 0; vec_n = 0; cnt_e = 0; err_e = 0;
      chk("rst_fin_valid", W'(fin_valid), 0);
      chk("rst_in_features", in_features, 0);
      chk("rst_modality", W'(fout_modality), 0);
      chk("rst_entries", W'(entries_sent), 0);
      chk("rst_frame_err", W'(frame_err), 0);
      chk("rst_s_ready", W'(s_ready), 1);
    end else begin
      chk("s_ready", W'(s_ready), W'(pend.size() < 2));
      chk("fin_valid", W'(fin_valid), W'(pend.size() > 0));
      if (pend.size() > 0) begin
        chk("in_features", in_features, pend[0].d);
        chk("modality", W'(fout_modality), W'(pend[0].m));
      end
      chk("entries_sent", W'(entries_sent), W'(cnt_e));
      chk("frame_err", W'(frame_err), W'(err_e));
      if (fin_valid && fin_ready) begin
        log_q.push_back({in_features, fout_modality});
        if (pend.size() > 0) begin
          if (pend[0].m) cnt_e++;
          void'(pend.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        err_e |= (s_last != (beat_i == 2 * FW - 1));
        beat_i = (beat_i + 1) % (2 * FW);
        part.push_back(s_feature);
        if (part.size() == FW) begin
          logic [W-1:0] v;
          for (int j = 0; j < FW; j++) v[j*NB +: NB] = part[j];
          pend.push_back({v, 1'(vec_n % 2)});
          vec_n++;
          part.delete();
        end
      end
    end
  end
  task automatic send(input logic [NB-1:0] d, input logic l);
    bit ok = 0;
    s_valid = 1; s_feature = d; s_last = l;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (s_ready) ok = 1; else stalls++;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      total++; bad++;
      $display("FAIL send_timeout got=stuck want=accepted");
    end
    s_valid = 0; s_last = 0;
  endtask
  task automatic send_entry(input int v0, input int a0, input int bad_beat, input bit no_last);
    for (int b = 0; b < 2 * FW; b++)
      send(b < FW ? NB'(v0 + b) : NB'(a0 - (b - FW)), ((b == 2 * FW - 1) && !no_last) || (b + 1 == bad_beat));
  endtask
  task automatic apply_reset();
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask
  task automatic settle();
    repeat (4) @(negedge clk);
  endtask
  initial begin
    logic [NB-1:0] pat [4];
    pat = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff};
    rst = 0; s_valid = 0; s_feature = 0; s_last = 0; fin_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    send_entry(1, -1, 0, 0);
    settle();
    chk("t1_count", W'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("t1_val", log_q[0].d, 160'h000a_0009_0008_0007_0006_0005_0004_0003_0002_0001);
      chk("t1_val_mod", W'(log_q[0].m), 0);
      chk("t1_aro", log_q[1].d, 160'hfff6_fff7_fff8_fff9_fffa_fffb_fffc_fffd_fffe_ffff);
      chk("t1_aro_mod", W'(log_q[1].m), 1);
    end
    chk("t1_entries", W'(entries_sent), 1);
    chk("t1_err", W'(frame_err), 0);
    apply_reset();
    fin_ready = 0;
    fork
      begin send_entry(1, -1, 0, 0); send_entry(21, -21, 0, 0); end
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t2_hold_ready", W'(s_ready), 0);
        chk("t2_hold_valid", W'(fin_valid), 1);
        chk("t2_hold_data", in_features, 160'h000a_0009_0008_0007_0006_0005_0004_0003_0002_0001);
        repeat (20) @(posedge clk);
        #1 fin_ready = 1;
      end
    join
    settle();
    chk("t2_count", W'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      chk("t2_order", W'({log_q[0].m, log_q[1].m, log_q[2].m, log_q[3].m}), 4'b0101);
      chk("t2_v1_lane0", W'(log_q[2].d[15:0]), 21);
    end
    chk("t2_entries", W'(entries_sent), 2);
    apply_reset();
    stalls = 0;
    for (int e = 0; e < 5; e++) send_entry(e * 100, -e * 100, 0, 0);
    settle();
    chk("t3_stalls", W'(stalls), 0);
    chk("t3_count", W'(log_q.size()), 10);
    chk("t3_entries", W'(entries_sent), 5);
    apply_reset();
    for (int b = 0; b < 2 * FW; b++) begin
      send(NB'(b + 1), (b == 2 * FW - 1) || (b == 6));
      if (b == 6) chk("t4_err_set", W'(frame_err), 1);
    end
    settle();
    chk("t4_err_held", W'(frame_err), 1);
    chk("t4_count", W'(log_q.size()), 2);
    if (log_q.size() == 2) chk("t4_data", log_q[0].d, 160'h000a_0009_0008_0007_0006_0005_0004_0003_0002_0001);
    apply_reset();
    send_entry(1, -1, 0, 1);
    settle();
    chk("t4_missing_last", W'(frame_err), 1);
    apply_reset();
    for (int b = 0; b < 13; b++) send(NB'(b + 1), 0);
    rst = 0;
    #1;
    chk("t5_valid", W'(fin_valid), 0);
    chk("t5_entries", W'(entries_sent), 0);
    chk("t5_ready", W'(s_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    send_entry(100, -100, 0, 0);
    settle();
    chk("t5_count", W'(log_q.size()), 2);
    if (log_q.size() == 2) chk("t5_lane0", W'(log_q[0].d[15:0]), 100);
    apply_reset();
    for (int b = 0; b < 2 * FW; b++) send(pat[b % FW % 4], b == 2 * FW - 1);
    settle();
    chk("t6_count", W'(log_q.size()), 2);
    if (log_q.size() == 2) chk("t6_slices", log_q[0].d, 160'h7fff_8000_ffff_0000_7fff_8000_ffff_0000_7fff_8000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
